// File: rtl/md5_pkg.sv
// Shared definitions for the MD5 hex digest streamer: FSM states and ASCII constants.
package md5_pkg;

  localparam int RESULT_W = 1024;

  localparam logic [7:0] CH_0  = 8'h30;
  localparam logic [7:0] CH_LA = 8'h61;
  localparam logic [7:0] CH_UA = 8'h41;
  localparam logic [7:0] CH_NL = 8'h0A;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    NL   = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/md5_nibble_to_ascii.sv
// Converts one 4-bit value into its ASCII hex digit.
module md5_nibble_to_ascii
  import md5_pkg::*;
#(
  parameter bit UPPERCASE = 1'b0
) (
  input  logic [3:0] i_nibble,
  output logic [7:0] o_char
);

  logic [7:0] w_alpha_base;

  assign w_alpha_base = UPPERCASE ? CH_UA : CH_LA;

  // digits 0-9 map from '0', digits 10-15 map from 'a' or 'A'
  always_comb begin
    if (i_nibble < 4'd10) begin
      o_char = CH_0 + {4'b0000, i_nibble};
    end else begin
      o_char = w_alpha_base + {4'b0000, i_nibble} - 8'd10;
    end
  end

endmodule

// File: rtl/md5_hex_digest_streamer.sv
// Streams a latched digest as ASCII hex characters over a valid/ready byte interface.
//
//  state | meaning
//  IDLE  | waiting for start
//  HI    | presenting high nibble of current byte
//  LO    | presenting low nibble of current byte
//  NL    | presenting line-feed terminator
//  DONE  | one-cycle completion pulse
module md5_hex_digest_streamer
  import md5_pkg::*;
#(
  parameter int MAX_BYTES = 128,
  parameter bit UPPERCASE = 1'b0,
  parameter bit APPEND_NL = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [RESULT_W-1:0] i_result,
  input  logic [7:0]          i_result_len,
  output logic                o_char_valid,
  output logic [7:0]          o_char_data,
  input  logic                i_char_ready,
  output logic                o_busy,
  output logic                o_done
);

  state_t              r_state;
  state_t              w_next;
  logic [RESULT_W-1:0] r_result;
  logic [7:0]          r_len;
  logic [7:0]          r_idx;
  logic [7:0]          r_byte;
  logic [7:0]          w_len_clamped;
  logic [7:0]          w_next_byte;
  logic [3:0]          w_nibble;
  logic [7:0]          w_hex_char;
  logic                w_accept;
  logic                w_xfer;
  logic                w_last;

  assign w_len_clamped = (i_result_len > 8'(MAX_BYTES)) ? 8'(MAX_BYTES) : i_result_len;
  assign w_accept      = (r_state == IDLE) && i_start;
  assign w_xfer        = o_char_valid && i_char_ready;
  assign w_last        = (r_idx == r_len - 8'd1);
  // r_byte always holds the byte at r_idx, so the next one is fetched as idx advances
  assign w_next_byte   = 8'(r_result >> {r_idx + 8'd1, 3'b000});
  assign w_nibble      = (r_state == LO) ? r_byte[3:0] : r_byte[7:4];

  md5_nibble_to_ascii #(
    .UPPERCASE(UPPERCASE)
  ) u_nib (
    .i_nibble(w_nibble),
    .o_char  (w_hex_char)
  );

  // latch digest and length on start, step the byte index after each low nibble
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_result <= '0;
      r_len    <= '0;
      r_idx    <= '0;
      r_byte   <= '0;
    end else if (w_accept) begin
      r_result <= i_result;
      r_len    <= w_len_clamped;
      r_idx    <= '0;
      r_byte   <= i_result[7:0];
    end else if ((r_state == LO) && w_xfer && !w_last) begin
      r_idx    <= r_idx + 8'd1;
      r_byte   <= w_next_byte;
    end
  end

  // state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // next-state logic; every character state holds until its handshake
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          if (w_len_clamped != 8'd0) w_next = HI;
          else if (APPEND_NL)        w_next = NL;
          else                       w_next = DONE;
        end
      end
      HI: if (w_xfer) w_next = LO;
      LO: begin
        if (w_xfer) begin
          if (!w_last)        w_next = HI;
          else if (APPEND_NL) w_next = NL;
          else                w_next = DONE;
        end
      end
      NL:      if (w_xfer) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // outputs decoded purely from state so reset drops them immediately
  always_comb begin
    o_char_valid = 1'b0;
    o_char_data  = 8'h00;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      HI, LO: begin
        o_char_valid = 1'b1;
        o_char_data  = w_hex_char;
        o_busy       = 1'b1;
      end
      NL: begin
        o_char_valid = 1'b1;
        o_char_data  = CH_NL;
        o_busy       = 1'b1;
      end
      DONE:    o_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_md5_hex_digest_streamer.sv
// Scoreboard bench: three streamer instances (lowercase+NL, uppercase+NL, lowercase no NL).
module tb_md5_hex_digest_streamer;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    start = '0;
  logic [2:0]    ready = '1;
  logic [1023:0] result = '0;
  logic [7:0]    result_len = '0;
  logic [2:0]    valid;
  logic [2:0]    busy;
  logic [2:0]    done;
  logic [2:0][7:0] data;

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] q [3][$];
  int mode [3]      = '{0, 0, 0};
  int mark [3]      = '{0, 0, 0};
  int d_mark [3]    = '{0, 0, 0};
  int acc_cnt [3]   = '{0, 0, 0};
  int done_cnt [3]  = '{0, 0, 0};
  int first_cyc [3] = '{0, 0, 0};
  int last_cyc [3]  = '{0, 0, 0};
  int done_cyc [3]  = '{0, 0, 0};
  logic       hold [3]  = '{1'b0, 1'b0, 1'b0};
  logic [7:0] hdata [3] = '{8'h00, 8'h00, 8'h00};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  md5_hex_digest_streamer #(.MAX_BYTES(128), .UPPERCASE(1'b0), .APPEND_NL(1'b1)) u_dut_lc (
    .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_result(result), .i_result_len(result_len),
    .o_char_valid(valid[0]), .o_char_data(data[0]), .i_char_ready(ready[0]),
    .o_busy(busy[0]), .o_done(done[0]));

  md5_hex_digest_streamer #(.MAX_BYTES(128), .UPPERCASE(1'b1), .APPEND_NL(1'b1)) u_dut_uc (
    .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_result(result), .i_result_len(result_len),
    .o_char_valid(valid[1]), .o_char_data(data[1]), .i_char_ready(ready[1]),
    .o_busy(busy[1]), .o_done(done[1]));

  md5_hex_digest_streamer #(.MAX_BYTES(128), .UPPERCASE(1'b0), .APPEND_NL(1'b0)) u_dut_nonl (
    .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_result(result), .i_result_len(result_len),
    .o_char_valid(valid[2]), .o_char_data(data[2]), .i_char_ready(ready[2]),
    .o_busy(busy[2]), .o_done(done[2]));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] hex_ch(input int k, input logic [3:0] n);
    string s;
    s = (k == 1) ? "0123456789ABCDEF" : "0123456789abcdef";
    return s[n];
  endfunction

  // ready driver: tied high, or random with 5-cycle stalls
  initial begin
    int stall [3];
    stall = '{0, 0, 0};
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        if (mode[k] == 0) begin
          ready[k] = 1'b1;
        end else if (stall[k] > 0) begin
          ready[k] = 1'b0;
          stall[k]--;
        end else if ($urandom_range(0, 3) == 0) begin
          ready[k] = 1'b0;
          stall[k] = 4;
        end else begin
          ready[k] = 1'b1;
        end
      end
    end
  end

  // monitor: pop scoreboard on every handshake, check stability during stalls
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (hold[k] && !rst) begin
        check_eq($sformatf("hold_valid%0d", k), valid[k], 1);
        check_eq($sformatf("hold_data%0d", k), data[k], hdata[k]);
      end
      if (valid[k] && ready[k]) begin
        check_eq($sformatf("q_avail%0d", k), q[k].size() != 0, 1);
        if (q[k].size() != 0) begin
          logic [7:0] e;
          e = q[k].pop_front();
          check_eq($sformatf("char%0d_n%0d", k, acc_cnt[k] - mark[k]), data[k], e);
        end
        if (acc_cnt[k] == mark[k]) first_cyc[k] = cyc;
        last_cyc[k] = cyc;
        acc_cnt[k]++;
      end
      hold[k]  = valid[k] && !ready[k] && !rst;
      hdata[k] = data[k];
      if (done[k]) begin
        done_cnt[k]++;
        done_cyc[k] = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int k, input logic [1023:0] res, input logic [7:0] len, output int t0);
    int nb;
    nb = (len > 8'd128) ? 128 : int'(len);
    for (int b = 0; b < nb; b++) begin
      logic [7:0] bv;
      bv = res[8*b +: 8];
      q[k].push_back(hex_ch(k, bv[7:4]));
      q[k].push_back(hex_ch(k, bv[3:0]));
    end
    if (k != 2) q[k].push_back(8'h0A);
    mark[k]    = acc_cnt[k];
    d_mark[k]  = done_cnt[k];
    result     = res;
    result_len = len;
    start[k]   = 1'b1;
    tick();
    start[k]   = 1'b0;
    t0         = cyc;
    check_eq($sformatf("busy_rise%0d", k), busy[k], (len != 0) || (k != 2));
  endtask

  task automatic finish(input int k, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt[k] != d_mark[k]) break;
      tick();
    end
    check_eq($sformatf("done_cnt%0d", k), done_cnt[k] - d_mark[k], 1);
    check_eq($sformatf("q_drain%0d", k), q[k].size(), 0);
    check_eq($sformatf("busy_end%0d", k), busy[k], 0);
    q[k].delete();
  endtask

  initial begin
    logic [1023:0] r_empty, r_ones, r_alt;
    int t0;
    int dm;

    r_empty = '0;
    r_empty[127:0] = 128'h7e42f8ec980009e904b2008fd98c1dd4;
    r_ones = '0;
    for (int b = 0; b < 128; b++) r_ones[8*b +: 8] = 8'hFF;
    r_alt = '0;
    r_alt[63:0] = 64'h0123456789abcdef;

    // reset values
    #3;
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("rst_valid%0d", k), valid[k], 0);
      check_eq($sformatf("rst_data%0d", k), data[k], 8'h00);
      check_eq($sformatf("rst_busy%0d", k), busy[k], 0);
      check_eq($sformatf("rst_done%0d", k), done[k], 0);
    end
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check_eq("idle_valid", valid[0], 0);

    // 1: empty-string digest, ready high, exact timing
    launch(0, r_empty, 8'd16, t0);
    finish(0, 100);
    check_eq("t1_count", acc_cnt[0] - mark[0], 33);
    check_eq("t1_first_lat", first_cyc[0] - t0, 0);
    check_eq("t1_span", last_cyc[0] - first_cyc[0], 32);
    check_eq("t1_done_lat", done_cyc[0] - last_cyc[0], 1);

    // 2: same digest with random ready stalls
    mode[0] = 1;
    launch(0, r_empty, 8'd16, t0);
    finish(0, 1000);
    mode[0] = 0;
    tick();
    check_eq("t2_count", acc_cnt[0] - mark[0], 33);

    // 3: zero length, with and without terminator
    launch(0, r_empty, 8'd0, t0);
    finish(0, 20);
    check_eq("t3_nl_count", acc_cnt[0] - mark[0], 1);
    launch(2, r_empty, 8'd0, t0);
    finish(2, 20);
    check_eq("t3_nonl_count", acc_cnt[2] - mark[2], 0);
    check_eq("t3_nonl_done_lat", done_cyc[2] - t0, 0);
    launch(2, r_alt, 8'd3, t0);
    finish(2, 40);
    check_eq("t3_nonl_len3", acc_cnt[2] - mark[2], 6);

    // 4: clamped length, lowercase and uppercase
    launch(0, r_ones, 8'd200, t0);
    finish(0, 400);
    check_eq("t4_lc_count", acc_cnt[0] - mark[0], 257);
    launch(1, r_ones, 8'd200, t0);
    finish(1, 400);
    check_eq("t4_uc_count", acc_cnt[1] - mark[1], 257);

    // 5: start during stream is ignored
    launch(0, r_empty, 8'd16, t0);
    repeat (10) tick();
    result     = r_alt;
    result_len = 8'd5;
    start[0]   = 1'b1;
    tick();
    start[0]   = 1'b0;
    check_eq("t5_busy", busy[0], 1);
    finish(0, 100);
    check_eq("t5_count", acc_cnt[0] - mark[0], 33);

    // 6: async reset mid-stream, then restart from byte 0
    launch(0, r_alt, 8'd8, t0);
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt[0] - mark[0] >= 7) break;
      tick();
    end
    check_eq("t6_reached7", acc_cnt[0] - mark[0] >= 7, 1);
    #2;
    rst = 1'b1;
    #1;
    check_eq("t6_valid_drop", valid[0], 0);
    check_eq("t6_busy_drop", busy[0], 0);
    check_eq("t6_data_clr", data[0], 8'h00);
    q[0].delete();
    dm = done_cnt[0];
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check_eq("t6_no_done", done_cnt[0] - dm, 0);
    check_eq("t6_idle_valid", valid[0], 0);
    launch(0, r_alt, 8'd8, t0);
    finish(0, 60);
    check_eq("t6_restart_count", acc_cnt[0] - mark[0], 17);
    check_eq("t6_restart_lat", first_cyc[0] - t0, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
